// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel to one registered mux with manual or round-robin grant.
//
// Parameters
//   WIDTH  data bits per channel (1..32)
//   NCH    number of input channels, power of two (2..16)
//   SELW   log2(NCH), set consistently by the instantiating module
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 = manual select via sel, 1 = round-robin arbitration
//   sel        channel index used in manual mode
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept (combinational, one-hot or zero)
//   out_data   registered data of the granted channel
//   out_ch     index of the channel that supplied out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  downstream accept
//   xfer_cnt   wrapping count of accepted input transfers

module rr_mux_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    localparam int unsigned CNTW = 16;

    logic [SELW-1:0]  last_grant;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  idx;
    logic             grant_valid;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // Output register may only take a new word when empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Gated by rst so no channel sees an accept while reset is held.
    assign xfer = load_en && grant_valid && !rst;

    // Grant selection. In round-robin mode the search runs from last_grant+1
    // upward; iterating the offsets in descending order lets the nearest
    // requesting channel win. Offset NCH wraps to last_grant itself.
    always_comb begin : arbitrate
        grant       = sel;
        grant_valid = in_valid[sel];
        idx         = '0;
        if (mode) begin
            grant       = last_grant;
            grant_valid = 1'b0;
            for (int k = int'(NCH); k >= 1; k--) begin
                idx = last_grant + SELW'(k);
                if (in_valid[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin : data_mux
        grant_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe to the granted channel only.
    always_comb begin : ready_decode
        in_ready = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            in_ready[i] = xfer && (grant == SELW'(i));
        end
    end

    // Output register, rotation pointer and transfer counter.
    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            xfer_cnt   <= '0;
            last_grant <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid  <= 1'b1;
                out_data   <= grant_data;
                out_ch     <= grant;
                last_grant <= grant;
                xfer_cnt   <= xfer_cnt + CNTW'(1);
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel, legal range 1..32.
REQ-002 Parameter NCH, default 4, number of input channels, power of two, legal range 2..16.
REQ-003 Parameter SELW, default 2, equals log2(NCH); the instantiating module sets it consistently with NCH.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: mode  input  1  0 = manual select, 1 = round-robin arbitration.
REQ-007 Port: sel  input  SELW  channel index used when mode=0.
REQ-008 Port: in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port: in_valid  input  NCH  per-channel request.
REQ-010 Port: in_ready  output  NCH  per-channel accept, one-hot or zero.
REQ-011 Port: out_data  output  WIDTH  registered selected data.
REQ-012 Port: out_ch  output  SELW  index of channel that supplied out_data.
REQ-013 Port: out_valid  output  1  out_data/out_ch hold a word.
REQ-014 Port: out_ready  input  1  downstream accept.
REQ-015 Port: xfer_cnt  output  16  count of accepted input transfers.

Function
REQ-016 load_en SHALL be (!out_valid || out_ready); output register may take a new word only when load_en=1.
REQ-017 mode=0: grant SHALL be channel sel, grant_valid = in_valid[sel]; other channels ignored.
REQ-018 mode=1: grant SHALL be first channel with in_valid=1 searching from (last_grant+1) mod NCH upward with wrap; grant_valid = |in_valid.
REQ-019 in_ready[grant] SHALL be 1 iff load_en && grant_valid; all other in_ready bits 0; in_ready is combinational.
REQ-020 Transfer (in_valid[g] && in_ready[g]) SHALL, at the next edge: out_data<=channel g data, out_ch<=g, out_valid<=1, last_grant<=g, xfer_cnt<=xfer_cnt+1.
REQ-021 load_en=1 with grant_valid=0 SHALL set out_valid<=0; out_data/out_ch hold previous values.
REQ-022 out_valid=1 && out_ready=0 SHALL hold out_data, out_ch, out_valid, last_grant, xfer_cnt unchanged; all in_ready = 0.
REQ-023 Latency: input accept to out_valid SHALL be exactly 1 cycle; full throughput of one word per cycle when out_ready=1 continuously.
REQ-024 last_grant SHALL update in both modes, so switching mode 0->1 resumes rotation after the last manually selected channel.
REQ-025 Mode or sel changes SHALL take effect on the grant in the same cycle (combinational); no word in the output register is affected.
REQ-026 xfer_cnt SHALL wrap from 16'hFFFF to 0 with no flag.
REQ-027 A channel whose in_valid drops before grant SHALL lose no state; no request is latched internally.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk: out_valid=0, out_data=0, out_ch=0, xfer_cnt=0, last_grant=NCH-1 (channel 0 first priority).
REQ-029 in_ready SHALL be all 0 while rst=1; reset asserted mid-stream discards the held word.
REQ-030 First transfer after rst deasserts SHALL occur no earlier than the first rising edge with rst=0.

Verification (WIDTH=8, NCH=4)
REQ-031 mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hC2, out_ready=1 -> in_ready=4'b0100; next cycle out_data=C2, out_ch=2, out_valid=1.
REQ-032 mode=1, in_valid=4'b1111 held, out_ready=1, after reset -> out_ch sequence 0,1,2,3,0,1; xfer_cnt=6 after six edges.
REQ-033 mode=1, in_valid=4'b1010, last_grant=1 -> grants 3,1,3; channels 0 and 2 never get in_ready.
REQ-034 out_valid=1, out_ready=0 for 3 cycles with all in_valid=1 -> in_ready=0, out_data/out_ch/xfer_cnt frozen; out_ready=1 -> new word loaded same edge old word accepted.
REQ-035 in_valid=0, out_ready=1 after a word -> out_valid falls next cycle; xfer_cnt unchanged.
REQ-036 rst pulsed between clock edges while out_valid=1, xfer_cnt=5 -> out_valid=0, xfer_cnt=0 before next edge; first grant after release is channel 0.
